// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared controller types for the key/value responder
//
// Purpose: operation command encoding, sub-command response struct and the
// responder FSM state type used by kv_store_responder.
// Ports: none (package).
package ctrl_types_pkg;

  // Encodings 3'b100..3'b111 are reserved and answered with an error.
  typedef enum logic [2:0] {
    OP_NOOP   = 3'b000,
    OP_READ   = 3'b001,
    OP_UPSERT = 3'b010,
    OP_DELETE = 3'b011
  } operation_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SCAN,
    R_COMMIT,
    R_RESP
  } resp_state_e;

endpackage

// File: rtl/kv_entry_array.sv
// rtl/kv_entry_array.sv - valid/key/value slot storage for the key/value store
//
// Purpose: holds NUM_ENTRIES slots. Only the valid bits are reset; key and
// value storage is left uninitialised since valid gates every use.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (valid bits only)
//   i_rd_idx            combinational read port index
//   o_rd_valid/key/value  slot contents at i_rd_idx
//   i_wr_idx            write port index
//   i_wr_data           write i_wr_key/i_wr_value into the slot
//   i_set_valid         mark the slot valid
//   i_clr_valid         mark the slot invalid
module kv_entry_array #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic                   o_rd_valid,
  output logic [KEY_WIDTH-1:0]   o_rd_key,
  output logic [VALUE_WIDTH-1:0] o_rd_value,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  logic                   i_wr_data,
  input  logic [KEY_WIDTH-1:0]   i_wr_key,
  input  logic [VALUE_WIDTH-1:0] i_wr_value,
  input  logic                   i_set_valid,
  input  logic                   i_clr_valid
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [KEY_WIDTH-1:0]   r_key   [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] r_value [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end else if (i_clr_valid) begin
      r_valid[i_wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_data) begin
      r_key[i_wr_idx]   <= i_wr_key;
      r_value[i_wr_idx] <= i_wr_value;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_key   = r_key[i_rd_idx];
  assign o_rd_value = r_value[i_rd_idx];

endmodule

// File: rtl/kv_store_responder.sv
// rtl/kv_store_responder.sv - executes READ/UPSERT/DELETE/NOOP against a small key/value store
//
// Purpose: accepts one operation at a time, linearly scans the slots (one per
// cycle), commits the action and returns a one-cycle {done, error} response.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op_valid_i      command strobe, accepted only while idle
//   op_i/key_i/value_i  command, key and write data
//   busy_o          high whenever a command is in flight
//   result_o        {done, error}; done pulses for one cycle
//   value_o         read data, valid while result_o.done=1, held otherwise
//   count_o         number of valid entries
module kv_store_responder
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               op_valid_i,
  input  operation_e                         op_i,
  input  logic [KEY_WIDTH-1:0]               key_i,
  input  logic [VALUE_WIDTH-1:0]             value_i,
  output logic                               busy_o,
  output sub_cmd_t                           result_o,
  output logic [VALUE_WIDTH-1:0]             value_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  resp_state_e            r_state;
  resp_state_e            w_state_nxt;
  operation_e             r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_free_idx;
  logic                   r_free_found;
  logic                   r_hit;
  logic                   r_error;
  logic [VALUE_WIDTH-1:0] r_value_o;
  logic [CNT_W-1:0]       r_count;

  logic                   w_rd_valid;
  logic [KEY_WIDTH-1:0]   w_rd_key;
  logic [VALUE_WIDTH-1:0] w_rd_value;
  logic                   w_hit;
  logic                   w_scan_op;
  logic [IDX_W-1:0]       w_wr_idx;
  logic                   w_wr_data;
  logic                   w_set_valid;
  logic                   w_clr_valid;
  logic                   w_commit_err;

  kv_entry_array #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .KEY_WIDTH   (KEY_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (r_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_key    (w_rd_key),
    .o_rd_value  (w_rd_value),
    .i_wr_idx    (w_wr_idx),
    .i_wr_data   (w_wr_data),
    .i_wr_key    (r_key),
    .i_wr_value  (r_value),
    .i_set_valid (w_set_valid),
    .i_clr_valid (w_clr_valid)
  );

  assign w_hit     = w_rd_valid && (w_rd_key == r_key);
  assign w_scan_op = (op_i == OP_READ) || (op_i == OP_UPSERT) || (op_i == OP_DELETE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the commit-time write controls for the slot array.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx     = r_idx;
    w_wr_data    = 1'b0;
    w_set_valid  = 1'b0;
    w_clr_valid  = 1'b0;
    w_commit_err = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (op_valid_i) begin
          w_state_nxt = w_scan_op ? R_SCAN : R_RESP;
        end
      end
      R_SCAN: begin
        if (w_hit || (r_idx == LAST_IDX)) begin
          w_state_nxt = R_COMMIT;
        end
      end
      R_COMMIT: begin
        w_state_nxt = R_RESP;
        case (r_op)
          OP_READ: begin
            w_commit_err = !r_hit;
          end
          OP_UPSERT: begin
            if (r_hit) begin
              w_wr_data = 1'b1;
            end else if (r_free_found) begin
              w_wr_idx    = r_free_idx;
              w_wr_data   = 1'b1;
              w_set_valid = 1'b1;
            end else begin
              w_commit_err = 1'b1;
            end
          end
          OP_DELETE: begin
            if (r_hit) begin
              w_clr_valid = 1'b1;
            end else begin
              w_commit_err = 1'b1;
            end
          end
          default: begin
            w_commit_err = 1'b1;
          end
        endcase
      end
      R_RESP: begin
        w_state_nxt = R_IDLE;
      end
      default: begin
        w_state_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_NOOP;
      r_key        <= '0;
      r_value      <= '0;
      r_idx        <= '0;
      r_free_idx   <= '0;
      r_free_found <= 1'b0;
      r_hit        <= 1'b0;
      r_error      <= 1'b0;
      r_value_o    <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (op_valid_i) begin
            r_op         <= op_i;
            r_key        <= key_i;
            r_value      <= value_i;
            r_idx        <= '0;
            r_free_idx   <= '0;
            r_free_found <= 1'b0;
            r_hit        <= 1'b0;
            // NOOP answers clean; reserved encodings answer with error.
            r_error      <= !(w_scan_op || (op_i == OP_NOOP));
          end
        end
        R_SCAN: begin
          if (w_hit) begin
            r_hit <= 1'b1;
          end else begin
            if (!w_rd_valid && !r_free_found) begin
              r_free_idx   <= r_idx;
              r_free_found <= 1'b1;
            end
            // Hold at the last slot; the FSM leaves R_SCAN there.
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        R_COMMIT: begin
          r_error <= w_commit_err;
          if (r_op == OP_READ) begin
            r_value_o <= r_hit ? w_rd_value : '0;
          end
          if (w_set_valid) begin
            r_count <= r_count + CNT_W'(1);
          end else if (w_clr_valid) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o         = (r_state != R_IDLE);
  assign result_o.done  = (r_state == R_RESP);
  assign result_o.error = (r_state == R_RESP) && r_error;
  assign value_o        = r_value_o;
  assign count_o        = r_count;

endmodule

// File: doc/kv_store_responder.md
Name: kv_store_responder

Overview:
- Responder side of the controller's operation interface.
- The controller issues an operation_e command (READ/UPSERT/DELETE/NOOP) with a key and value. This block executes it against a small fully-associative key/value store and returns a sub_cmd_t {done, error} plus read data.
- It sits below the top controller FSM (ST_GET/ST_UPSERT/ST_DEL states) and is the unit those states wait on.

Parameters:
- NUM_ENTRIES, 8, number of key/value slots (power of two, >=2)
- KEY_WIDTH, 16, key width in bits
- VALUE_WIDTH, 32, value width in bits

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_valid_i  input  1  command strobe; accepted only in IDLE
- op_i  input  3  operation_e command
- key_i  input  KEY_WIDTH  command key
- value_i  input  VALUE_WIDTH  write data for UPSERT
- busy_o  output  1  high whenever not in IDLE
- result_o  output  2  sub_cmd_t {done, error}; done is a one-cycle pulse
- value_o  output  VALUE_WIDTH  read data, valid while result_o.done=1
- count_o  output  $clog2(NUM_ENTRIES+1)  number of valid entries

Behaviour:
- Reset (async assert, sync release):
  - state=R_IDLE; all valid bits=0; count_o=0.
  - busy_o=0; result_o=2'b00; value_o=0.
  - Key/value storage is not reset.
  - Reset mid-operation abandons the command with no response.
- Accept: op_valid_i=1 and state R_IDLE at a rising edge. The block latches op_i, key_i and value_i. Inputs are ignored while busy_o=1; there is no queueing.
- FSM states:
  - R_IDLE: wait for a command.
    - READ/UPSERT/DELETE -> R_SCAN with idx=0 and free_found=0.
    - NOOP -> R_RESP with error=0.
    - Encodings 3'b100..3'b111 -> R_RESP with error=1.
  - R_SCAN: examine entry idx, one entry per cycle.
    - valid[idx] && key[idx]==latched key -> record hit and idx, go to R_COMMIT.
    - Otherwise, if !valid[idx] and !free_found -> record idx as free_idx and set free_found.
    - idx==NUM_ENTRIES-1 without a hit -> R_COMMIT with miss.
    - Otherwise idx+1.
  - R_COMMIT: perform the action and register the response.
    - READ hit: value_o<=value[idx], error=0.
    - READ miss: value_o<=0, error=1.
    - UPSERT hit: value[idx]<=latched value, count unchanged, error=0.
    - UPSERT miss with free_found: write key/value at free_idx, set valid, count+1, error=0.
    - UPSERT miss without free_found (full): no write, error=1.
    - DELETE hit: valid[idx]<=0, count-1, error=0.
    - DELETE miss: error=1.
    - Go to R_RESP.
  - R_RESP: result_o.done=1 for exactly this cycle, with error as registered. Return to R_IDLE next cycle. result_o returns to 2'b00 in IDLE.
  - value_o holds its last value outside R_RESP.
- Latency, counted from the accept edge = cycle 0:
  - Hit at slot k: done visible in cycle k+3.
  - Miss: done visible in cycle NUM_ENTRIES+2.
  - NOOP/illegal: done visible in cycle 1.
- Throughput: a new command may be accepted in the cycle after R_RESP, when busy_o is already 0.
- Width rules:
  - idx and free_idx are $clog2(NUM_ENTRIES) bits; idx saturates at the last slot, with no wrap, because the FSM leaves R_SCAN there.
  - count_o never exceeds NUM_ENTRIES and never underflows, since it only changes on a hit-delete or a free-slot insert.
- The first free slot in index order is used for inserts.
- At most one valid entry per key is an invariant; UPSERT of an existing key never allocates.

Decomposition:
- Add to ctrl_types_pkg:
  - typedef enum logic [1:0] resp_state_e {R_IDLE, R_SCAN, R_COMMIT, R_RESP}.
  - Reuse operation_e and sub_cmd_t unchanged; result_o is typed sub_cmd_t and op_i is typed operation_e.
- One natural sub-module, kv_entry_array:
  - Holds valid/key/value registers.
  - One combinational read port by index and one write port (set, clear, data write).
  - Async reset of valid bits only.
- The FSM, scan index and counter stay in kv_store_responder.

Test Plan:
- Reset, then READ key 0x0042 -> done+error (2'b11) in cycle 10 (8-entry miss), value_o=0, count_o=0.
- UPSERT key 0x0042 value 0xDEADBEEF, then READ 0x0042:
  - UPSERT -> 2'b10 in cycle 10, count_o=1.
  - READ hit at slot 0 -> 2'b10 in cycle 3, value_o=0xDEADBEEF.
- UPSERT 0x0042 value 0x12345678 (overwrite) -> 2'b10 in cycle 3, count_o stays 1; a following READ returns 0x12345678.
- Fill 8 distinct keys 0x0001..0x0008 -> count_o=8; UPSERT 0x0009 -> 2'b11, count_o=8; READ 0x0009 -> 2'b11.
- With slots 0..7 full:
  - DELETE 0x0004 (slot 3) -> 2'b10 in cycle 6, count_o=7.
  - UPSERT 0x0009 -> 2'b10 (written in slot 3); READ 0x0009 hits in cycle 6.
  - DELETE 0x0004 again -> 2'b11.
- Edge cases:
  - NOOP -> 2'b10 in cycle 1.
  - op_i=3'b101 -> 2'b11 in cycle 1.
  - op_valid_i pulsed while busy_o=1 -> ignored.
  - rst_n asserted mid-R_SCAN -> busy_o=0, count_o=0 immediately, with no done pulse.
